// File: rtl/fetch_unit.sv
// PC register and instruction-fetch sequencer: it fetches the instruction at pc over
// req/ack, holds it for decode over valid/ready, and commits next_pc when it retires.
module fetch_unit #(
    parameter int              BITS     = 8,
    parameter logic [BITS-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] next_pc,
    output logic [BITS-1:0] pc,
    output logic [BITS-1:0] pc_inc,
    output logic            imem_req,
    output logic [BITS-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [BITS-1:0] imem_data,
    output logic [BITS-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            halt,
    output logic            halted,
    output logic [1:0]      dbg_state
);

    // Handshakes: imem_req/imem_ack complete a fetch in any cycle where both are 1;
    // instr_valid/instr_ready retire the held instruction in any cycle where both are 1.
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_VALID  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e          state_q;
    logic [BITS-1:0] pc_q;
    logic [BITS-1:0] instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_data;
                        state_q <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        pc_q    <= next_pc;
                        state_q <= halt ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Status outputs are decoded from state and forced low while rst is held.
    assign imem_req    = (state_q == S_FETCH)  && !rst;
    assign instr_valid = (state_q == S_VALID)  && !rst;
    assign halted      = (state_q == S_HALTED) && !rst;

    assign pc        = pc_q;
    assign pc_inc    = pc_q + BITS'(1);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a vector table, directed corner-case sequences, and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_fetch_unit;

    localparam int         BITS     = 8;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] next_pc = '0;
    logic [7:0] pc, pc_inc, imem_addr, instr;
    logic       imem_req, instr_valid, halted;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = '0;
    logic       instr_ready = 1'b0;
    logic       halt = 1'b0;
    logic [1:0] dbg_state;

    fetch_unit #(.BITS(BITS), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .pc(pc), .pc_inc(pc_inc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halt(halt), .halted(halted), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: does the core hold an instruction, is it stopped, where is it.
    logic [7:0] m_pc, m_instr;
    bit         m_have, m_halted, m_known;
    logic [7:0] mem [256];
    bit         rnd_mode = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input bit r, input bit ack, input logic [7:0] data,
                         input bit rdy, input bit hlt, input logic [7:0] npc);
        rst = r; imem_ack = ack; imem_data = data;
        instr_ready = rdy; halt = hlt; next_pc = npc;
    endtask

    // Wait to mid-cycle and compare every output with the model.
    task automatic sample();
        @(negedge clk);
        if (m_known) begin
            chk("pc", pc, m_pc);
            chk("pc_inc", pc_inc, 8'(m_pc + 8'd1));
            chk("imem_addr", imem_addr, m_pc);
            chk("instr", instr, m_instr);
            chk("imem_req", imem_req, !rst && !m_halted && !m_have);
            chk("instr_valid", instr_valid, !rst && m_have);
            chk("halted", halted, !rst && m_halted);
            if (rnd_mode && !rst && m_have && instr_ready) exp_q.push_back(mem[m_pc]);
            if (rnd_mode && instr_valid && instr_ready && !rst) begin
                if (exp_q.size() == 0) chk("retire_sb_empty", 1, 0);
                else chk("retire_sb", instr, exp_q.pop_front());
            end
        end
    endtask

    // Advance one clock and step the model with the inputs that were sampled.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC; m_instr = 8'h00; m_have = 0; m_halted = 0; m_known = 1;
            exp_q.delete();
        end else if (m_halted) begin
            m_halted = 1;
        end else if (!m_have) begin
            if (imem_ack) begin m_instr = imem_data; m_have = 1; end
        end else if (instr_ready) begin
            m_pc = next_pc; m_have = 0;
            if (halt) m_halted = 1;
        end
        #1;
    endtask

    task automatic cyc(input bit r, input bit ack, input logic [7:0] data,
                       input bit rdy, input bit hlt, input logic [7:0] npc);
        apply(r, ack, data, rdy, hlt, npc);
        sample();
        tick();
    endtask

    typedef struct {
        bit         rst, ack, rdy, hlt;
        logic [7:0] data, npc;
        bit         e_req, e_valid, e_halted;
        logic [7:0] e_pc, e_instr;
    } vec_t;

    vec_t       vt [11];
    logic [7:0] wrap_pc [3];

    function automatic vec_t mkv(bit r, bit ack, logic [7:0] d, bit rdy, bit hlt,
                                 logic [7:0] npc, bit er, bit ev, bit eh,
                                 logic [7:0] ep, logic [7:0] ei);
        vec_t v;
        v.rst = r; v.ack = ack; v.data = d; v.rdy = rdy; v.hlt = hlt; v.npc = npc;
        v.e_req = er; v.e_valid = ev; v.e_halted = eh; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        m_known = 0;
        //          rst ack data  rdy hlt npc    req val hlt pc     instr
        vt[0]  = mkv(1, 0, 8'h00, 0, 0, 8'h00,  0,  0,  0, 8'h00, 8'h00);
        vt[1]  = mkv(0, 1, 8'h5A, 0, 0, 8'h00,  1,  0,  0, 8'h00, 8'h00);
        vt[2]  = mkv(0, 0, 8'h00, 0, 0, 8'h00,  0,  1,  0, 8'h00, 8'h5A);
        vt[3]  = mkv(0, 0, 8'h00, 1, 0, 8'h37,  0,  1,  0, 8'h00, 8'h5A);
        vt[4]  = mkv(0, 0, 8'h00, 0, 0, 8'h00,  1,  0,  0, 8'h37, 8'h5A);
        vt[5]  = mkv(0, 1, 8'h11, 0, 0, 8'h00,  1,  0,  0, 8'h37, 8'h5A);
        vt[6]  = mkv(0, 1, 8'h99, 0, 1, 8'h00,  0,  1,  0, 8'h37, 8'h11);
        vt[7]  = mkv(0, 0, 8'h00, 1, 1, 8'h10,  0,  1,  0, 8'h37, 8'h11);
        vt[8]  = mkv(0, 1, 8'h22, 1, 0, 8'h00,  0,  0,  1, 8'h10, 8'h11);
        vt[9]  = mkv(1, 0, 8'h00, 0, 0, 8'h00,  0,  0,  0, 8'h10, 8'h11);
        vt[10] = mkv(0, 0, 8'h00, 0, 0, 8'h00,  1,  0,  0, 8'h00, 8'h00);

        // First reset edge: DUT state is undefined before it, so nothing is compared.
        cyc(1, 0, 8'h00, 0, 0, 8'h00);

        for (int i = 0; i < 11; i++) begin
            apply(vt[i].rst, vt[i].ack, vt[i].data, vt[i].rdy, vt[i].hlt, vt[i].npc);
            sample();
            chk($sformatf("vec%0d_req", i), imem_req, vt[i].e_req);
            chk($sformatf("vec%0d_valid", i), instr_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_halted", i), halted, vt[i].e_halted);
            chk($sformatf("vec%0d_pc", i), pc, vt[i].e_pc);
            chk($sformatf("vec%0d_instr", i), instr, vt[i].e_instr);
            tick();
        end

        // Wait states: three cycles without ack, then ack.
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 8'h00, 0, 0, 8'h00);
            sample();
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, 8'h00);
            chk("wait_valid", instr_valid, 0);
            tick();
        end
        apply(0, 1, 8'hC3, 0, 0, 8'h00);
        sample();
        chk("ack_cycle_req", imem_req, 1);
        chk("ack_cycle_valid", instr_valid, 0);
        tick();
        apply(0, 1, 8'hEE, 0, 0, 8'h00);
        sample();
        chk("after_ack_valid", instr_valid, 1);
        chk("after_ack_instr", instr, 8'hC3);
        tick();
        apply(0, 0, 8'h00, 0, 0, 8'h00);
        sample();
        chk("spurious_ack_instr", instr, 8'hC3);
        tick();
        cyc(0, 0, 8'h00, 1, 0, 8'hFE);

        // Sequential retire across the wrap.
        wrap_pc[0] = 8'hFE; wrap_pc[1] = 8'hFF; wrap_pc[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 8'($urandom_range(0, 255)), 1, 0, 8'(m_pc + 8'd1));
            apply(0, 0, 8'h00, 1, 0, 8'(m_pc + 8'd1));
            sample();
            chk("wrap_pc", pc, wrap_pc[i]);
            chk("wrap_pc_inc", pc_inc, 8'(wrap_pc[i] + 8'd1));
            tick();
        end

        // Backpressure for five cycles, then a jump.
        cyc(0, 1, 8'h6B, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            apply(0, $urandom_range(0, 1), 8'($urandom_range(0, 255)), 0,
                  $urandom_range(0, 1), 8'($urandom_range(0, 255)));
            sample();
            chk("stall_pc", pc, 8'h01);
            chk("stall_instr", instr, 8'h6B);
            chk("stall_valid", instr_valid, 1);
            tick();
        end
        cyc(0, 0, 8'h00, 1, 0, 8'h37);
        apply(0, 0, 8'h00, 0, 0, 8'h00);
        sample();
        chk("jump_pc", pc, 8'h37);
        chk("jump_addr", imem_addr, 8'h37);
        chk("jump_req", imem_req, 1);
        tick();

        // Halt: ignored without ready, then taken and held for 20 cycles.
        cyc(0, 1, 8'h42, 0, 0, 8'h00);
        cyc(0, 0, 8'h00, 0, 1, 8'h55);
        cyc(0, 0, 8'h00, 1, 1, 8'h10);
        for (int i = 0; i < 20; i++) begin
            apply(0, $urandom_range(0, 1), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 255)));
            sample();
            chk("halt_halted", halted, 1);
            chk("halt_pc", pc, 8'h10);
            chk("halt_req", imem_req, 0);
            tick();
        end

        // Reset out of HALTED.
        cyc(1, 1, 8'h77, 1, 1, 8'h33);
        apply(0, 0, 8'h00, 0, 0, 8'h00);
        sample();
        chk("rst_halt_halted", halted, 0);
        chk("rst_halt_req", imem_req, 1);
        chk("rst_halt_pc", pc, RESET_PC);
        chk("rst_halt_instr", instr, 8'h00);
        tick();

        // Reset in FETCH together with an ack carrying 0xAA.
        cyc(1, 1, 8'hAA, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 8'h00, 0, 0, 8'h00);
            sample();
            chk("rst_fetch_instr", instr, 8'h00);
            chk("rst_fetch_valid", instr_valid, 0);
            chk("rst_fetch_req", imem_req, 1);
            chk("rst_fetch_pc", pc, RESET_PC);
            tick();
        end

        // Randomized run against the model, memory contents from mem[].
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            bit       r;
            bit [7:0] npc;
            r   = ($urandom_range(0, 59) == 0);
            npc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(m_pc + 8'd1);
            cyc(r, $urandom_range(0, 1), mem[imem_addr], $urandom_range(0, 1),
                ($urandom_range(0, 15) == 0), npc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter register and instruction-fetch sequencer for the 8-bit core, sitting directly downstream of `next_pc`. It holds the architectural PC, drives instruction memory with a req/ack handshake, and presents the fetched instruction to decode with a valid/ready handshake. It feeds `pc_inc` back as the `pc` input of `next_pc`, and commits `next_pc`'s result when the current instruction retires.

## Interface

- `BITS`, default 8, width of the PC, instruction memory address and instruction word.
- `RESET_PC`, default 0, PC value loaded on reset.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `next_pc`  input  BITS  PC to commit at retire; from `next_pc` block.
- `pc`  output  BITS  current architectural PC.
- `pc_inc`  output  BITS  `pc + 1` mod 2^BITS; combinational; drives `next_pc.pc`.
- `imem_req`  output  1  fetch request to instruction memory.
- `imem_addr`  output  BITS  fetch address; always equals `pc`.
- `imem_ack`  input  1  memory returns `imem_data` this cycle; only meaningful while `imem_req`=1.
- `imem_data`  input  BITS  instruction word, valid when `imem_ack`=1.
- `instr`  output  BITS  instruction register contents.
- `instr_valid`  output  1  `instr` holds the instruction at `pc`.
- `instr_ready`  input  1  decode/execute retires `instr` this cycle.
- `halt`  input  1  from decode; sampled only on retire; retiring instruction is the last.
- `halted`  output  1  core stopped; no further fetches.

## Operation

- The state machine is one-hot or encoded; the choice is free. It has 3 states: FETCH, VALID, HALTED.
- **FETCH**:
  - `imem_req`=1, `instr_valid`=0.
  - On `imem_ack`=1: `instr` <= `imem_data`; go to VALID.
  - Otherwise stay in FETCH, with `imem_req` held high and `imem_addr` stable.
- **VALID**:
  - `imem_req`=0, `instr_valid`=1, `instr` stable.
  - On `instr_ready`=1: `pc` <= `next_pc`.
    - If `halt`=1, go to HALTED.
    - Otherwise, go to FETCH.
  - Otherwise hold all state.
- **HALTED**:
  - `halted`=1, `imem_req`=0, `instr_valid`=0.
  - `pc` and `instr` are frozen.
  - Only `rst` exits this state.
- `imem_ack` outside FETCH is ignored; no state change, no `instr` update.
- `instr_ready` outside VALID is ignored.
- `halt` without `instr_ready` is ignored.
- PC arithmetic is unsigned modulo 2^BITS. `pc_inc` at `pc`=0xFF is 0x00; no carry or flag.
- `next_pc` is committed exactly as presented. Branch/jump target selection is entirely upstream.

## Timing

- **Reset** (`rst`=1 at a rising edge) sets, on that edge:
  - `pc`=`RESET_PC`, `instr`=0, state=FETCH.
  - Outputs while `rst` is high: `imem_req`=0, `instr_valid`=0, `halted`=0.
- **First fetch**: `imem_req`=1 in the first cycle with `rst`=0, with `imem_addr`=`RESET_PC`.
- **Reset mid-operation**: reset wins over every other input in any state, including FETCH with `imem_ack`=1 and VALID with `instr_ready`=1. An in-flight fetch is dropped.
- **Fetch latency**: if `imem_ack` is high in FETCH cycle N, then `instr_valid`=1 in cycle N+1.
  - Memory may ack in the same cycle as the first request.
  - Wait states are unbounded.
- **Retire**: if `instr_ready`=1 in VALID cycle M, then:
  - the new `pc` is visible in cycle M+1;
  - `imem_req`=1 in cycle M+1 (or `halted`=1 if `halt` was also 1).
- **Throughput**: best case is one instruction per 2 cycles.
- **Outputs**: all outputs are registered or decoded from state, except `pc_inc` and `imem_addr`. `pc_inc` is combinational from `pc`; `imem_addr` is a direct copy of `pc`. There is no combinational path from `instr_ready` or `imem_ack` to any output.

## Test plan

- **Reset then fetch**:
  - Stimulus: hold `rst` 2 cycles, release; memory acks immediately with 0x5A.
  - Required response: cycle 1 `imem_req`=1 with `imem_addr`=0x00; cycle 2 `instr`=0x5A and `instr_valid`=1.
- **Wait states**:
  - Stimulus: ack delayed 3 cycles.
  - Required response: `imem_req` and `imem_addr` stay stable for all 4 cycles; `instr_valid` stays 0 until the cycle after ack.
  - Stimulus: a spurious `imem_ack` in VALID.
  - Required response: `instr` is unchanged.
- **Sequential retire and wrap**:
  - Stimulus: drive `next_pc`=`pc_inc` with `instr_ready` always 1, starting at `pc`=0xFE.
  - Required response: `pc` goes 0xFE -> 0xFF -> 0x00; `pc_inc` at 0xFF reads 0x00.
- **Jump commit and backpressure**:
  - Stimulus: in VALID, hold `instr_ready`=0 for 5 cycles, then retire with `next_pc`=0x37.
  - Required response: `pc` and `instr` are held through the stall; next cycle `pc`=0x37, `imem_addr`=0x37, `imem_req`=1.
- **Halt**:
  - Stimulus: retire with `halt`=1 and `next_pc`=0x10.
  - Required response: next cycle `halted`=1 and `pc`=0x10; `imem_req` remains 0 for 20 cycles regardless of `imem_ack` or `instr_ready`.
  - Stimulus: `halt`=1 with `instr_ready`=0.
  - Required response: no effect.
- **Reset mid-operation**:
  - Stimulus: assert `rst` in FETCH together with `imem_ack`=1 and `imem_data`=0xAA; separately, assert `rst` in HALTED.
  - Required response:
    - Each case: `pc`=`RESET_PC` and `instr`=0; `instr_valid` stays 0.
    - FETCH case: 0xAA is never captured.
    - HALTED case: `halted` clears.
    - Both cases: fetch restarts the cycle after `rst` falls.
